// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer for the microwave front panel: debounces the encoder,
// shifts accepted digits into an M:SS BCD register and hands it to the cook timer.
module keypad_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       valid,
  input  logic       start,
  input  logic       clear,
  input  logic       done,
  output logic       enablen,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       cooking
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    RELEASE_WAIT = 3'd3,
    COOKING      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_Z   = CNT_W'(0);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_digit, w_digit_nxt;
  logic [3:0]       r_min, r_tens, r_ones;
  logic [3:0]       w_min_nxt, w_tens_nxt, w_ones_nxt;
  logic             r_load, r_cooking, r_enablen;
  logic             w_load_nxt;
  logic             w_digits_zero;

  assign w_digits_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

  // Next-state logic; priority is clear > done > start > digit accept.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_min_nxt   = r_min;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_load_nxt  = 1'b0;
    if (r_state == COOKING) begin
      if (clear || done) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_Z;
        w_min_nxt   = 4'd0;
        w_tens_nxt  = 4'd0;
        w_ones_nxt  = 4'd0;
      end else begin
        w_state_nxt = COOKING;
      end
    end else if (clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = CNT_Z;
      w_min_nxt   = 4'd0;
      w_tens_nxt  = 4'd0;
      w_ones_nxt  = 4'd0;
    end else if (start && !w_digits_zero) begin
      // Any accept pending this cycle is dropped; the timer gets the old digits.
      w_state_nxt = COOKING;
      w_cnt_nxt   = CNT_Z;
      w_load_nxt  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid) begin
            w_digit_nxt = D;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = PRESS_WAIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        PRESS_WAIT: begin
          if (r_cnt >= DEB) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = CNT_Z;
            if (r_digit <= 4'd9) begin
              w_min_nxt  = r_tens;
              w_tens_nxt = r_ones;
              w_ones_nxt = r_digit;
            end else begin
              w_ones_nxt = r_ones;
            end
          end else if (valid && (D == r_digit)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end else begin
            w_cnt_nxt   = CNT_Z;
            w_state_nxt = IDLE;
          end
        end
        HELD: begin
          if (!valid) begin
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = RELEASE_WAIT;
          end else begin
            w_state_nxt = HELD;
          end
        end
        RELEASE_WAIT: begin
          if (r_cnt >= DEB) begin
            w_cnt_nxt   = CNT_Z;
            w_state_nxt = IDLE;
          end else if (valid) begin
            w_cnt_nxt   = CNT_Z;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_cnt_nxt   = CNT_Z;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, digit and output registers; enablen/cooking follow the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= CNT_Z;
      r_digit   <= 4'd0;
      r_min     <= 4'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_load    <= 1'b0;
      r_cooking <= 1'b0;
      r_enablen <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_digit   <= w_digit_nxt;
      r_min     <= w_min_nxt;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_load    <= w_load_nxt;
      r_cooking <= (w_state_nxt == COOKING);
      r_enablen <= (w_state_nxt != COOKING);
    end
  end

  assign enablen  = r_enablen;
  assign cooking  = r_cooking;
  assign load     = r_load;
  assign min_ones = r_min;
  assign sec_tens = r_tens;
  assign sec_ones = r_ones;

endmodule
